// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clk_div_pkg;

  // Default divisor / counter width used by the standalone type below.
  localparam int unsigned DIV_BUS_DEF = 32;

  // Smallest divisor that produces a running channel; anything below idles it.
  localparam int unsigned CLK_DIV_MIN = 2;

  typedef logic [DIV_BUS_DEF-1:0] div_t;

  // One channel's programmable configuration.
  typedef struct packed {
    div_t div;
    div_t high;
  } ch_cfg_t;

endpackage

// File: rtl/clk_div_multi_if.sv
// Control / status bundle between the clock divider and its host.
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DIV_BUS = 32
);

  logic [NUM_CH-1:0]              en;
  logic                           load;
  logic [NUM_CH-1:0][DIV_BUS-1:0] div;
  logic [NUM_CH-1:0][DIV_BUS-1:0] high;
  logic [NUM_CH-1:0]              outclk;
  logic [NUM_CH-1:0]              tick;
  logic [NUM_CH-1:0]              pending;

  modport master (
    output en, load, div, high,
    input  outclk, tick, pending
  );

  modport slave (
    input  en, load, div, high,
    output outclk, tick, pending
  );

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, double-buffered divisor / high-count,
// and the pending flag that defers a retune to the next period boundary.
// Programmable duty is compiled in with CLK_DIV_DUTY_CFG_EN; without it the
// high phase is floor(div/2).
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_BUS = 32,
  parameter int unsigned DEF_DIV = 1_000_000
) (
  input  logic               inclk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               load_i,
  input  logic [DIV_BUS-1:0] div_i,
`ifdef CLK_DIV_DUTY_CFG_EN
  input  logic [DIV_BUS-1:0] high_i,
`endif
  output logic               outclk_o,
  output logic               tick_o,
  output logic               pending_o
);

  localparam logic [DIV_BUS-1:0] ZERO_C     = DIV_BUS'(0);
  localparam logic [DIV_BUS-1:0] ONE_C      = DIV_BUS'(1);
  localparam logic [DIV_BUS-1:0] MIN_DIV_C  = DIV_BUS'(CLK_DIV_MIN);
  localparam logic [DIV_BUS-1:0] DEF_DIV_C  = DIV_BUS'(DEF_DIV);
  localparam logic [DIV_BUS-1:0] DEF_HIGH_C = DEF_DIV_C >> 1;

  logic [DIV_BUS-1:0] cnt_q, cnt_d;
  logic [DIV_BUS-1:0] act_div_q, act_div_d;
  logic [DIV_BUS-1:0] act_high_q, act_high_d;
  logic [DIV_BUS-1:0] sh_div_q, sh_div_d;
  logic [DIV_BUS-1:0] sh_high_q, sh_high_d;
  logic               pending_q, pending_d;
  logic               outclk_q, outclk_d;
  logic               tick_q, tick_d;

  logic               running_s;
  logic               last_s;
  logic               apply_s;
  logic [DIV_BUS-1:0] req_high_s;

  // High-count requested by a load: from the port, or half the divisor.
  always_comb begin
`ifdef CLK_DIV_DUTY_CFG_EN
    req_high_s = high_i;
`else
    req_high_s = div_i >> 1;
`endif
  end

  // Next-state: counter/outputs, boundary apply of the shadow, shadow capture.
  always_comb begin
    running_s = en_i && (act_div_q >= MIN_DIV_C);
    // act_div-1 is only formed when act_div >= 2, so it never wraps.
    if (running_s) begin
      last_s = (cnt_q == (act_div_q - ONE_C));
    end else begin
      last_s = 1'b0;
    end
    apply_s = pending_q && (!running_s || last_s);

    if (running_s) begin
      outclk_d = (cnt_q < act_high_q);
      tick_d   = (cnt_q == ZERO_C);
      if (last_s) begin
        cnt_d = ZERO_C;
      end else begin
        cnt_d = cnt_q + ONE_C;
      end
    end else begin
      outclk_d = 1'b0;
      tick_d   = 1'b0;
      cnt_d    = ZERO_C;
    end

    // The apply uses the pre-edge shadow, so a coincident load waits a period.
    if (apply_s) begin
      act_div_d  = sh_div_q;
      act_high_d = sh_high_q;
    end else begin
      act_div_d  = act_div_q;
      act_high_d = act_high_q;
    end

    if (load_i) begin
      sh_div_d  = div_i;
      sh_high_d = req_high_s;
      pending_d = 1'b1;
    end else begin
      sh_div_d  = sh_div_q;
      sh_high_d = sh_high_q;
      if (apply_s) begin
        pending_d = 1'b0;
      end else begin
        pending_d = pending_q;
      end
    end
  end

  // State registers; reset restores the default divisor in both banks.
  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      cnt_q      <= ZERO_C;
      act_div_q  <= DEF_DIV_C;
      act_high_q <= DEF_HIGH_C;
      sh_div_q   <= DEF_DIV_C;
      sh_high_q  <= DEF_HIGH_C;
      pending_q  <= 1'b0;
      outclk_q   <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      act_div_q  <= act_div_d;
      act_high_q <= act_high_d;
      sh_div_q   <= sh_div_d;
      sh_high_q  <= sh_high_d;
      pending_q  <= pending_d;
      outclk_q   <= outclk_d;
      tick_q     <= tick_d;
    end
  end

  assign outclk_o  = outclk_q;
  assign tick_o    = tick_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider top: NUM_CH independent channels sharing one
// load strobe. Build option CLK_DIV_DUTY_CFG_EN enables the per-channel
// high-count input; otherwise each channel runs at floor(div/2) high.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DIV_BUS = 32,
  parameter int unsigned DEF_DIV = 1_000_000
) (
  input  logic            inclk,
  input  logic            rst,
  clk_div_multi_if.slave  bus
);

  logic [NUM_CH-1:0] outclk_s;
  logic [NUM_CH-1:0] tick_s;
  logic [NUM_CH-1:0] pending_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .DIV_BUS (DIV_BUS),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .inclk     (inclk),
      .rst       (rst),
      .en_i      (bus.en[g]),
      .load_i    (bus.load),
      .div_i     (bus.div[g]),
`ifdef CLK_DIV_DUTY_CFG_EN
      .high_i    (bus.high[g]),
`endif
      .outclk_o  (outclk_s[g]),
      .tick_o    (tick_s[g]),
      .pending_o (pending_s[g])
    );
  end

  assign bus.outclk  = outclk_s;
  assign bus.tick    = tick_s;
  assign bus.pending = pending_s;

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi (2 channels, 8-bit, default divisor 4).
module tb_clk_div_multi;

  localparam int NCH = 2;
  localparam int DW  = 8;
  localparam int DEF = 4;

  logic inclk = 1'b0;
  logic rst;

  always #5 inclk = ~inclk;

  clk_div_multi_if #(.NUM_CH(NCH), .DIV_BUS(DW)) bus ();

  clk_div_multi #(.NUM_CH(NCH), .DIV_BUS(DW), .DEF_DIV(DEF)) dut (
    .inclk (inclk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position within the period plus active/shadow settings.
  int m_pos  [NCH];
  int m_div  [NCH];
  int m_high [NCH];
  int m_sdiv [NCH];
  int m_shigh[NCH];
  logic [NCH-1:0] m_pend, m_o, m_t;

  function automatic int req_high(int d, int h);
`ifdef CLK_DIV_DUTY_CFG_EN
    return h;
`else
    return d / 2;
`endif
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_pos[c] = 0; m_div[c] = DEF; m_high[c] = DEF / 2;
      m_sdiv[c] = DEF; m_shigh[c] = DEF / 2;
    end
    m_pend = '0; m_o = '0; m_t = '0;
  endtask

  task automatic model_edge();
    bit run, wrap, apply;
    int hi;
    for (int c = 0; c < NCH; c++) begin
      run   = bus.en[c] && (m_div[c] >= 2);
      wrap  = run && (m_pos[c] == m_div[c] - 1);
      apply = m_pend[c] && (!run || wrap);
      if (run) begin
        hi = (m_high[c] < m_div[c]) ? m_high[c] : m_div[c];
        m_o[c] = (m_pos[c] < hi);
        m_t[c] = (m_pos[c] == 0);
        m_pos[c] = (m_pos[c] + 1) % m_div[c];
      end else begin
        m_o[c] = 1'b0; m_t[c] = 1'b0; m_pos[c] = 0;
      end
      if (apply) begin
        m_div[c] = m_sdiv[c]; m_high[c] = m_shigh[c];
      end
      if (bus.load) begin
        m_sdiv[c]  = int'(bus.div[c]);
        m_shigh[c] = req_high(int'(bus.div[c]), int'(bus.high[c]));
        m_pend[c]  = 1'b1;
      end else if (apply) begin
        m_pend[c] = 1'b0;
      end
    end
  endtask

  // One clock: model follows the edge, then sample at the falling edge.
  task automatic step();
    @(posedge inclk);
    model_edge();
    @(negedge inclk);
  endtask

  task automatic set_load(input int d, input int h);
    bus.load = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      bus.div[c]  = DW'(d);
      bus.high[c] = DW'(h);
    end
  endtask

  task automatic do_reset(input logic [NCH-1:0] en_v);
    rst = 1'b1;
    bus.load = 1'b0;
    bus.en = en_v;
    model_reset();
    repeat (2) @(negedge inclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] pat;
    pat = 8'b1100_1100;
    rst = 1'b1; bus.en = '0; bus.load = 1'b0; bus.div = '0; bus.high = '0;
    model_reset();
    @(negedge inclk);
    n_checks++;
    if ({bus.outclk, bus.tick, bus.pending} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_state: got %b expected 000000", {bus.outclk, bus.tick, bus.pending});
    end
    bus.en = 2'b01;
    @(negedge inclk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if ({bus.outclk, bus.tick, bus.pending} !== {m_o, m_t, m_pend}) begin
        n_errors++;
        $display("FAIL reset_model cyc%0d: got %b expected %b", i, {bus.outclk, bus.tick, bus.pending}, {m_o, m_t, m_pend});
      end
      n_checks++;
      if ({bus.outclk[1], bus.outclk[0], bus.tick[0]} !== {1'b0, pat[7-i], (i % 4 == 0)}) begin
        n_errors++;
        $display("FAIL reset_pattern cyc%0d: got out1=%b out0=%b tick0=%b expected 0 %b %b", i, bus.outclk[1], bus.outclk[0], bus.tick[0], pat[7-i], (i % 4 == 0));
      end
    end
  endtask

  task automatic test_retune();
    logic [4:0] pat;
`ifdef CLK_DIV_DUTY_CFG_EN
    pat = 5'b10000;
`else
    pat = 5'b11000;
`endif
    do_reset(2'b01);
    step();
    set_load(5, 1);
    step();
    bus.load = 1'b0;
    n_checks++;
    if (bus.pending[0] !== 1'b1) begin
      n_errors++; $display("FAIL retune_pending_set: got %b expected 1", bus.pending[0]);
    end
    step();
    n_checks++;
    if (bus.pending[0] !== 1'b1 || bus.outclk[0] !== 1'b0) begin
      n_errors++; $display("FAIL retune_pending_hold: got pend=%b out=%b expected 1 0", bus.pending[0], bus.outclk[0]);
    end
    step();
    n_checks++;
    if (bus.pending[0] !== 1'b0 || bus.outclk[0] !== 1'b0) begin
      n_errors++; $display("FAIL retune_wrap: got pend=%b out=%b expected 0 0", bus.pending[0], bus.outclk[0]);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if ({bus.outclk, bus.tick, bus.pending} !== {m_o, m_t, m_pend}) begin
        n_errors++;
        $display("FAIL retune_model cyc%0d: got %b expected %b", i, {bus.outclk, bus.tick, bus.pending}, {m_o, m_t, m_pend});
      end
      n_checks++;
      if (bus.outclk[0] !== pat[4 - (i % 5)]) begin
        n_errors++;
        $display("FAIL retune_pattern cyc%0d: got %b expected %b", i, bus.outclk[0], pat[4 - (i % 5)]);
      end
    end
  endtask

  task automatic test_double_load();
    logic [5:0] pat;
    pat = 6'b100_100;
    do_reset(2'b01);
    step();
    set_load(6, 3);
    step();
    set_load(3, 1);
    step();
    bus.load = 1'b0;
    n_checks++;
    if (bus.pending[0] !== 1'b1) begin
      n_errors++; $display("FAIL dbl_pending_set: got %b expected 1", bus.pending[0]);
    end
    step();
    n_checks++;
    if (bus.pending[0] !== 1'b0) begin
      n_errors++; $display("FAIL dbl_pending_clear: got %b expected 0", bus.pending[0]);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if ({bus.outclk, bus.tick, bus.pending} !== {m_o, m_t, m_pend}) begin
        n_errors++;
        $display("FAIL dbl_model cyc%0d: got %b expected %b", i, {bus.outclk, bus.tick, bus.pending}, {m_o, m_t, m_pend});
      end
      n_checks++;
      if (bus.outclk[0] !== pat[5-i]) begin
        n_errors++; $display("FAIL dbl_pattern cyc%0d: got %b expected %b", i, bus.outclk[0], pat[5-i]);
      end
    end
  endtask

  task automatic test_load_on_apply();
    logic [7:0] opat, ppat;
    opat = 8'b11000_100;
    ppat = 8'b11110_000;
    do_reset(2'b01);
    step();
    set_load(5, 2);
    step();
    bus.load = 1'b0;
    step();
    set_load(3, 1);
    step();
    bus.load = 1'b0;
    n_checks++;
    if (bus.pending[0] !== 1'b1) begin
      n_errors++; $display("FAIL coinc_pending_kept: got %b expected 1", bus.pending[0]);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if ({bus.outclk, bus.tick, bus.pending} !== {m_o, m_t, m_pend}) begin
        n_errors++;
        $display("FAIL coinc_model cyc%0d: got %b expected %b", i, {bus.outclk, bus.tick, bus.pending}, {m_o, m_t, m_pend});
      end
      n_checks++;
      if ({bus.outclk[0], bus.pending[0]} !== {opat[7-i], ppat[7-i]}) begin
        n_errors++;
        $display("FAIL coinc_pattern cyc%0d: got out=%b pend=%b expected %b %b", i, bus.outclk[0], bus.pending[0], opat[7-i], ppat[7-i]);
      end
    end
  endtask

  task automatic test_idle_divs();
    int dv [2];
    logic [3:0] pat;
    dv[0] = 1; dv[1] = 0;
    pat = 4'b1010;
    for (int k = 0; k < 2; k++) begin
      do_reset(2'b01);
      step();
      step();
      set_load(dv[k], 0);
      step();
      bus.load = 1'b0;
      step();
      for (int i = 0; i < 6; i++) begin
        step();
        n_checks++;
        if ({bus.outclk[0], bus.tick[0]} !== 2'b00 || {bus.outclk, bus.tick, bus.pending} !== {m_o, m_t, m_pend}) begin
          n_errors++;
          $display("FAIL idle_div%0d cyc%0d: got %b expected %b with ch0 out/tick 00", dv[k], i, {bus.outclk, bus.tick, bus.pending}, {m_o, m_t, m_pend});
        end
      end
      set_load(2, 1);
      step();
      bus.load = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
        step();
        n_checks++;
        if ({bus.outclk[0], bus.tick[0]} !== {pat[3-i], pat[3-i]} || {bus.outclk, bus.tick, bus.pending} !== {m_o, m_t, m_pend}) begin
          n_errors++;
          $display("FAIL restart_div2 cyc%0d: got out0=%b tick0=%b expected %b %b", i, bus.outclk[0], bus.tick[0], pat[3-i], pat[3-i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pat;
    pat = 8'b1100_1100;
    do_reset(2'b01);
    step();
    set_load(7, 3);
    step();
    bus.load = 1'b0;
    n_checks++;
    if ({bus.outclk[0], bus.pending[0]} !== 2'b11) begin
      n_errors++; $display("FAIL rstmid_before: got out=%b pend=%b expected 1 1", bus.outclk[0], bus.pending[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({bus.outclk, bus.tick, bus.pending} !== 6'b0) begin
      n_errors++; $display("FAIL rstmid_async: got %b expected 000000", {bus.outclk, bus.tick, bus.pending});
    end
    @(negedge inclk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (bus.outclk[0] !== pat[7-i] || {bus.outclk, bus.tick, bus.pending} !== {m_o, m_t, m_pend}) begin
        n_errors++;
        $display("FAIL rstmid_after cyc%0d: got %b expected %b ch0 out %b", i, {bus.outclk, bus.tick, bus.pending}, {m_o, m_t, m_pend}, pat[7-i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset(2'b11);
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 24) == 0) bus.en[c] = ~bus.en[c];
        bus.div[c]  = DW'($urandom_range(0, 9));
        bus.high[c] = DW'($urandom_range(0, 10));
      end
      bus.load = ($urandom_range(0, 9) == 0);
      step();
      n_checks++;
      if ({bus.outclk, bus.tick, bus.pending} !== {m_o, m_t, m_pend}) begin
        n_errors++;
        $display("FAIL random cyc%0d: got out=%b tick=%b pend=%b expected out=%b tick=%b pend=%b", i, bus.outclk, bus.tick, bus.pending, m_o, m_t, m_pend);
      end
    end
    bus.load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_retune();
    test_double_load();
    test_load_on_apply();
    test_idle_divs();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock divider for the lab clock tree. It generates NUM_CH independent divided clocks from `inclk`, each with its own programmable period, plus a one-cycle tick marking each period start. New divisor values are double-buffered and take effect only at a period boundary, so a retune never produces a runt pulse. It replaces the single-channel, fixed-50%-duty divider in tone, LED-blink and sampling-rate paths.

## Interface
- NUM_CH, 4, number of independent output channels (1..16)
- DIV_BUS, 32, width of divisor, high-count and counter
- DEF_DIV, 1_000_000, per-channel divisor loaded at reset (50 Hz from 50 MHz)

- inclk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- en  input  NUM_CH  per-channel run enable
- load  input  1  strobe: capture `div`/`high` into all channels' shadow registers
- div  input  NUM_CH x DIV_BUS  requested period in inclk cycles
- high  input  NUM_CH x DIV_BUS  requested high-phase length in inclk cycles (used only with DUTY_CFG_EN)
- outclk  output  NUM_CH  divided clock, registered
- tick  output  NUM_CH  one-cycle pulse, registered, on the cycle outclk starts a period
- pending  output  NUM_CH  shadow value captured but not yet active

## Operation
- Per channel, the state is: counter, act_div, act_high, sh_div, sh_high, pending.
- Reset values: counter 0; act_div = sh_div = DEF_DIV; act_high = sh_high = DEF_DIV >> 1; pending 0; outclk 0; tick 0.
- A channel is running when en=1 and act_div >= 2. On each inclk edge while running:
  - outclk <= (counter < act_high)
  - tick <= (counter == 0)
  - counter <= (counter == act_div-1) ? 0 : counter+1
- A channel is idle when en=0 or act_div < 2. While idle: counter <= 0, outclk <= 0, tick <= 0.
- High-count boundaries: act_high=0 gives constant 0; act_high >= act_div gives constant 1. tick still pulses every period in both cases.
- load=1 at an edge sets sh_div/sh_high <= div/high and pending <= 1 for every channel.
- Apply condition: pending=1 and the channel is either idle or at counter == act_div-1. On apply:
  - act_div/act_high <= sh_div/sh_high (the pre-edge shadow value)
  - pending clears, unless load is also 1 at the same edge
- load while already pending overwrites the shadow. Only the last value written before the boundary is applied.
- All arithmetic is unsigned DIV_BUS-bit. act_div-1 is evaluated only when act_div >= 2, so it cannot underflow.

## Timing
- outclk and tick lag the counter by one cycle.
- From the first running edge after en rises: outclk=1 and tick=1 are visible after that edge.
- Period is exactly act_div cycles. High phase is min(act_high, act_div) cycles.
- Retune latency: new values take effect on the first edge after the current period completes, at most act_div cycles after load. There is no partial period.
- en falling: outclk drops to 0 at the next edge and the counter restarts from 0 when en returns.
- rst mid-period: all outputs go to 0 immediately (asynchronous), and shadows return to DEF_DIV.
- Channels are mutually independent; there is no phase alignment between channels.

## Configuration
- `CLK_DIV_DUTY_CFG_EN` defined: act_high/sh_high are taken from the `high` port, giving programmable duty.
- `CLK_DIV_DUTY_CFG_EN` undefined: the `high` port is ignored and act_high = act_div >> 1 (floor). Example: div=5 gives 2 cycles high, 3 cycles low.

## Structure
- Package `clk_div_pkg` holds:
  - typedef `div_t` (logic [DIV_BUS-1:0], default width 32)
  - a struct for channel config {div, high}
  - constant `CLK_DIV_MIN = 2`
- Sub-module `clk_div_channel` implements one channel (counter, shadow/active registers, pending logic). The top level instantiates it NUM_CH times in a generate loop and shares `load` across all channels.

## Test plan
Bench configuration: NUM_CH=2, DIV_BUS=8, DEF_DIV=4.
- Reset release with en=2'b01: ch0 outclk repeats 1,1,0,0; tick pulses every 4th cycle; ch1 outclk holds 0.
- DUTY_CFG_EN, load with div=5, high=1 mid-period: pending=1 until the wrap, then the pattern becomes 1,0,0,0,0; no short pulse appears at the transition.
- Two loads (div=6, then div=3) before a boundary: only div=3 is applied; pending clears at the wrap.
- load on the same edge as the apply: the old shadow becomes active, pending stays 1, and the new value is applied at the following wrap.
- div=1, high=0, div=0 each loaded: the channel goes idle (outclk 0, no tick); a later load of div=2 restarts it with a 1,0 pattern.
- Assert rst mid-high-phase: outclk/tick/pending go to 0 immediately; after release, outclk returns to the DEF_DIV=4 pattern.
